reg_scoreboard_tracker: RTL
===========================

// Module: reg_scoreboard_tracker
// PURPOSE
//  Parametrised stateful register scoreboard for the decode/RF stage. It replaces
//  the per-stage OR of EX/ME scoreboard vectors with per-lane in-flight writer
//  counters: incremented when a writer issues, decremented at writeback.
//  Checks NUM_SRC source operands and one destination against the live counters
//  and produces DEP_STALL. One instance each serves GPR, SEG and MM files.
// PARAMETERS
//  NUM_REGS  8  architectural registers tracked
//  ID_W      3  register id width (2**ID_W >= NUM_REGS)
//  LANES     3  sub-register lanes per reg (GPR: b[7:0], b[15:8], b[31:16]; SEG/MM use 1)
//  NUM_SRC   4  source operand check ports (SR1, SR2, SR3, SIB index)
//  CNT_W     2  counter width; max in-flight writers per lane = 2**CNT_W-1
// PORTS
//  CLK           in   1                clock, all state updates on rising edge
//  RST           in   1                asynchronous, active-low reset
//  STAGE_V       in   1                checking stage holds a valid instruction
//  SRC_NEEDED    in   NUM_SRC          per-source valid
//  SRC_ID        in   NUM_SRC*ID_W     per-source register id, src k at [k*ID_W +: ID_W]
//  SRC_MASK      in   NUM_SRC*LANES    per-source lanes read
//  DST_NEEDED    in   1                instruction writes a register of this file
//  DST_ID        in   ID_W             destination register id
//  DST_MASK      in   LANES            destination lanes written
//  ISSUE         in   1                stage advancing this cycle (from pipeline ctl)
//  WB_V          in   1                writeback retiring a writer this cycle
//  WB_ID         in   ID_W             writeback register id
//  WB_MASK       in   LANES            writeback lanes
//  FLUSH         in   1                pipeline flush; all in-flight writers squashed
//  DEP_STALL     out  1                hold the stage
//  SRC_STALL     out  NUM_SRC          per-source hazard (debug/perf)
//  OVF_STALL     out  1                destination lane counter saturated
//  PENDING       out  NUM_REGS*LANES   lane has >=1 in-flight writer, reg r lane l at r*LANES+l
//  BUSY          out  1                any PENDING bit set
//  ERR           out  1                sticky: writeback to lane with zero count
// BEHAVIOUR
//  - State: cnt[r][l] (CNT_W bits) per reg/lane, plus ERR flop. RST low -> all cnt=0,
//    ERR=0, immediately (async); hence DEP_STALL=0, SRC_STALL=0, OVF_STALL=0,
//    PENDING=0, BUSY=0 while in reset.
//  - All stall outputs are combinational from registered cnt only; no same-cycle
//    bypass of WB (conservative: a WB in cycle N clears the hazard in cycle N+1).
//  - SRC_STALL[k] = STAGE_V & SRC_NEEDED[k] & |(SRC_MASK[k] & PENDING[SRC_ID[k]]).
//    Ids >= NUM_REGS never stall.
//  - OVF_STALL = STAGE_V & DST_NEEDED & any lane in DST_MASK with cnt == max.
//  - DEP_STALL = |SRC_STALL | OVF_STALL. WAW on a non-saturated lane does not stall.
//  - inc = ISSUE & STAGE_V & DST_NEEDED & ~DEP_STALL & ~FLUSH; ISSUE while DEP_STALL=1
//    is a control error and is ignored (no increment).
//  - dec = WB_V & ~FLUSH.
//  - Per lane, next cnt: FLUSH -> 0; inc&dec same lane -> unchanged; inc -> +1;
//    dec -> -1 if cnt>0, else stays 0 and ERR<=1. Increment never wraps (OVF_STALL
//    guarantees cnt < max on inc).
//  - Latency: issue at edge N -> PENDING visible from cycle N+1; WB at edge N ->
//    cleared from cycle N+1 if count reaches 0.
//  - FLUSH has priority over inc/dec; clears counters only, ERR held until RST.
//  - Partial lanes: a WB_MASK narrower than its DST_MASK leaves other lanes pending;
//    producers must write back with the same mask they issued.
//  - STAGE_V=0 forces all stall outputs to 0 and suppresses inc; WB still applies.
// TESTING
//  1 Reset mid-traffic: cnt[2]=1, drop RST async -> PENDING=0, DEP_STALL=0 before next edge.
//  2 RAW: issue DST_ID=3 mask 3'b001; next cycle SRC_ID=3 mask 3'b001 -> DEP_STALL=1;
//    WB id 3 mask 001 -> DEP_STALL=0 the following cycle.
//  3 Lane isolation: pending reg 1 lane0 only; source reads reg 1 mask 3'b010 -> no stall;
//    mask 3'b011 -> SRC_STALL bit set.
//  4 Saturation: CNT_W=2, issue reg 5 three times -> cnt=3, 4th -> OVF_STALL=1, no
//    increment; same cycle WB reg 5 -> cnt=2, OVF_STALL=0 next cycle.
//  5 Simultaneous inc/dec same lane at cnt=1 -> cnt stays 1, PENDING held.
//  6 FLUSH with cnt[0..7]!=0 plus concurrent issue/WB -> all cnt=0, BUSY=0 next cycle;
//    WB to zero lane -> ERR=1, persists through FLUSH, cleared only by RST.

Source files
------------

// File: rtl/reg_scoreboard_tracker.sv
// Register scoreboard for the decode/RF stage. Each register lane carries a
// small counter of in-flight writers: a writer issuing from this stage bumps
// the count, its writeback drops it. Source operands and the destination are
// checked against the registered counts to produce the stage hold.
module reg_scoreboard_tracker #(
  parameter int NUM_REGS = 8,
  parameter int ID_W     = 3,
  parameter int LANES    = 3,
  parameter int NUM_SRC  = 4,
  parameter int CNT_W    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        stage_v,
  input  logic [NUM_SRC-1:0]          src_needed,
  input  logic [NUM_SRC*ID_W-1:0]     src_id,
  input  logic [NUM_SRC*LANES-1:0]    src_mask,
  input  logic                        dst_needed,
  input  logic [ID_W-1:0]             dst_id,
  input  logic [LANES-1:0]            dst_mask,
  input  logic                        issue,
  input  logic                        wb_v,
  input  logic [ID_W-1:0]             wb_id,
  input  logic [LANES-1:0]            wb_mask,
  input  logic                        flush,
  output logic                        dep_stall,
  output logic [NUM_SRC-1:0]          src_stall,
  output logic                        ovf_stall,
  output logic [NUM_REGS*LANES-1:0]   pending,
  output logic                        busy,
  output logic                        err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt      [NUM_REGS][LANES];
  logic             inc_lane [NUM_REGS][LANES];
  logic             dec_lane [NUM_REGS][LANES];
  logic             inc;
  logic             dec;

  // A lane is pending while any writer to it is still in flight.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the loops can leave it unassigned and infer a latch.
    pending = '0;
    for (int r = 0; r < NUM_REGS; r++)
      for (int l = 0; l < LANES; l++)
        pending[r*LANES+l] = (cnt[r][l] != '0);
  end

  assign busy = |pending;

  // Hazard checks read only registered counts; a writeback this cycle does not
  // release a stall until the next cycle. Ids with no matching register never
  // match the loop below and therefore never stall.
  always_comb begin
    src_stall = '0;
    ovf_stall = 1'b0;
    for (int k = 0; k < NUM_SRC; k++)
      for (int r = 0; r < NUM_REGS; r++)
        if (src_id[k*ID_W +: ID_W] == ID_W'(r))
          src_stall[k] = stage_v & src_needed[k] &
                         (|(src_mask[k*LANES +: LANES] & pending[r*LANES +: LANES]));
    for (int r = 0; r < NUM_REGS; r++)
      for (int l = 0; l < LANES; l++)
        if (stage_v && dst_needed && dst_id == ID_W'(r) && dst_mask[l] &&
            cnt[r][l] == CNT_MAX)
          ovf_stall = 1'b1;
  end

  assign dep_stall = (|src_stall) | ovf_stall;

  // An issue attempted while stalled is ignored; flush squashes both sides.
  assign inc = issue & stage_v & dst_needed & ~dep_stall & ~flush;
  assign dec = wb_v & ~flush;

  // Decode which lanes this cycle's issue and writeback touch.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++)
      for (int l = 0; l < LANES; l++) begin
        inc_lane[r][l] = inc & (dst_id == ID_W'(r)) & dst_mask[l];
        dec_lane[r][l] = dec & (wb_id == ID_W'(r)) & wb_mask[l];
      end
  end

  // Per-lane counter update with flush priority; sticky error on underflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the counter array is real state whose zero value means "no hazard",
      // so every entry is reset, unlike a data RAM whose contents may start unknown.
      for (int r = 0; r < NUM_REGS; r++)
        for (int l = 0; l < LANES; l++)
          cnt[r][l] <= '0;
      err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every lane reading the pre-edge
      // counts, so lanes cannot see each other's updates within one edge.
      for (int r = 0; r < NUM_REGS; r++)
        for (int l = 0; l < LANES; l++) begin
          if (flush) begin
            cnt[r][l] <= '0;
          end else if (inc_lane[r][l] && dec_lane[r][l]) begin
            cnt[r][l] <= cnt[r][l];
          end else if (inc_lane[r][l]) begin
            cnt[r][l] <= cnt[r][l] + CNT_W'(1);
          end else if (dec_lane[r][l]) begin
            if (cnt[r][l] != '0) cnt[r][l] <= cnt[r][l] - CNT_W'(1);
            else                 err <= 1'b1;
          end
        end
    end
  end

endmodule
